// File: rtl/finder_pattern_scanner_pkg.sv
// Shared types and constants for the QR finder-pattern scanner.
// Widths cover frames up to 1024 pixels per side and runs up to 511 pixels.
package finder_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SCAN_H,
        S_DRAIN_H,
        S_SCAN_V,
        S_DRAIN_V,
        S_DONE
    } scan_state_t;

    localparam int PIXEL_LATENCY = 2;
    // One extra cycle lets the run tracker consume the last returned pixel.
    localparam int DRAIN_CYCLES  = PIXEL_LATENCY + 1;

    localparam logic PIX_WHITE = 1'b1;
    localparam logic PIX_BLACK = 1'b0;

    localparam int ADDR_W  = 20;
    localparam int COORD_W = 10;
    localparam int RUN_W   = 9;
    localparam int UNIT_W  = 11;
    localparam int DIFF_W  = 14;

    // Completed-run window; index 4 is the newest run, index 0 the oldest.
    typedef logic [4:0][RUN_W-1:0] run_win_t;

    function automatic logic signed [DIFF_W-1:0] to_s(input logic [UNIT_W-1:0] v);
        return $signed(DIFF_W'(v));
    endfunction

    function automatic logic signed [DIFF_W-1:0] abs_s(input logic signed [DIFF_W-1:0] v);
        return (v < 0) ? -v : v;
    endfunction

endpackage

// File: rtl/finder_pattern_scanner_if.sv
// Start/done handshake, frame-buffer read port and result vectors of the scanner.
// The scanner is the slave; whoever starts it and serves pixels is the master.
interface finder_pattern_scanner_if #(
    parameter int WIDTH  = 480,
    parameter int HEIGHT = 480
);
    logic              start_scan;
    logic              pixel_reading;
    logic [19:0]       address_reading;
    logic [WIDTH-1:0]  horz_patterns;
    logic [HEIGHT-1:0] vert_patterns;
    logic              busy;
    logic              patterns_valid;

    modport master (
        output start_scan,
        output pixel_reading,
        input  address_reading,
        input  horz_patterns,
        input  vert_patterns,
        input  busy,
        input  patterns_valid
    );

    modport slave (
        input  start_scan,
        input  pixel_reading,
        output address_reading,
        output horz_patterns,
        output vert_patterns,
        output busy,
        output patterns_valid
    );
endinterface

// File: rtl/finder_pattern_scanner_run_tracker.sv
// Per-line run-length tracker with a five-run window and 1:1:3:1:1 ratio test.
// Emits a strobe with the centre coordinate of every accepted pattern.
module finder_run_tracker
    import finder_pkg::*;
#(
    parameter int MIN_UNIT = 4
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               vld,
    input  logic               line_start,
    input  logic               line_end,
    input  logic               pixel,
    input  logic [COORD_W-1:0] coord,
    output logic               center_vld,
    output logic [DIFF_W-1:0]  center
);

    logic             active_q;
    logic             colour_q;
    logic [RUN_W-1:0] cur_q;
    run_win_t         win_q;
    logic [2:0]       cnt_q;

    logic                     act;
    logic                     col;
    logic [RUN_W-1:0]         cur;
    run_win_t                 win;
    run_win_t                 hit_win;
    logic [2:0]               cnt;
    logic                     hit;
    logic signed [DIFF_W-1:0] last_black;
    logic signed [DIFF_W-1:0] centre;

    function automatic logic ratio_ok(input run_win_t w);
        logic [UNIT_W-1:0]        u;
        logic signed [DIFF_W-1:0] su;
        logic signed [DIFF_W-1:0] tol;
        logic                     ok;
        u   = UNIT_W'(w[0]) + UNIT_W'(w[1]) + UNIT_W'(w[3]) + UNIT_W'(w[4]);
        su  = to_s(u);
        tol = su >>> 1;
        ok  = (u >= UNIT_W'(MIN_UNIT));
        for (int i = 0; i < 5; i++) begin
            if (i != 2) begin
                ok = ok && (abs_s((to_s(UNIT_W'(w[i])) <<< 2) - su) <= tol);
            end
        end
        ok = ok && (abs_s((to_s(UNIT_W'(w[2])) <<< 2) - (su + su + su)) <= su);
        return ok;
    endfunction

    // At most one black run completes per pixel, so one check per cycle suffices:
    // a colour change retires the old run, a line end then retires the final one.
    always_comb begin
        act        = active_q;
        col        = colour_q;
        cur        = cur_q;
        win        = win_q;
        cnt        = cnt_q;
        hit        = 1'b0;
        hit_win    = '0;
        last_black = '0;
        if (line_start) begin
            act = 1'b0;
            cur = '0;
            cnt = '0;
        end
        if (act && (pixel != col)) begin
            win = {cur, win[4:1]};
            if ((col == PIX_BLACK) && (cnt == 3'd4)) begin
                hit        = 1'b1;
                hit_win    = win;
                last_black = to_s(UNIT_W'(coord)) - 14'sd1;
                cnt        = 3'd3;
            end else begin
                cnt = cnt + 3'd1;
            end
            cur = RUN_W'(1);
            col = pixel;
        end else if (act) begin
            cur = cur + RUN_W'(1);
        end else if (pixel == PIX_BLACK) begin
            act = 1'b1;
            cur = RUN_W'(1);
            col = PIX_BLACK;
        end
        if (line_end && act) begin
            win = {cur, win[4:1]};
            if ((col == PIX_BLACK) && (cnt == 3'd4)) begin
                hit        = 1'b1;
                hit_win    = win;
                last_black = to_s(UNIT_W'(coord));
                cnt        = 3'd3;
            end else begin
                cnt = cnt + 3'd1;
            end
            act = 1'b0;
        end
    end

    assign centre = last_black
                  - to_s(UNIT_W'(hit_win[4]))
                  - to_s(UNIT_W'(hit_win[3]))
                  - to_s(UNIT_W'(hit_win[2] >> 1));

    assign center_vld = vld && hit && ratio_ok(hit_win);
    assign center     = centre;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            active_q <= 1'b0;
            colour_q <= 1'b0;
            cur_q    <= '0;
            win_q    <= '0;
            cnt_q    <= '0;
        end else if (vld) begin
            active_q <= act;
            colour_q <= col;
            cur_q    <= cur;
            win_q    <= win;
            cnt_q    <= cnt;
        end
    end

endmodule

// File: rtl/finder_pattern_scanner.sv
// Two-pass (row-major, then column-major) finder-pattern scan of the binary frame buffer.
// Marks centre columns in horz_patterns and centre rows in vert_patterns.
module finder_pattern_scanner
    import finder_pkg::*;
#(
    parameter int WIDTH    = 480,
    parameter int HEIGHT   = 480,
    parameter int MIN_UNIT = 4
) (
    input  logic clk_in,
    input  logic rst_in,
    finder_pattern_scanner_if.slave bus
);

    localparam logic [COORD_W-1:0] W_LAST = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(HEIGHT - 1);
    localparam logic [WIDTH-1:0]   H_ONE  = WIDTH'(1);
    localparam logic [HEIGHT-1:0]  V_ONE  = HEIGHT'(1);

    scan_state_t state_q;
    scan_state_t state_d;

    logic [1:0]         drain_q;
    logic               drain_last;
    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] y_q;
    logic [COORD_W-1:0] inner;
    logic [COORD_W-1:0] outer;
    logic               inner_last;
    logic               scan_last;
    logic               scanning;
    logic               vert_pass;
    logic [ADDR_W-1:0]  address_q;

    logic               vld_p0, vld_p1, vld_p2;
    logic               pass_p0, pass_p1, pass_p2;
    logic [COORD_W-1:0] coord_p0, coord_p1, coord_p2;
    logic               first_p0, first_p1, first_p2;
    logic               last_p0, last_p1, last_p2;

    logic [WIDTH-1:0]   horz_q;
    logic [HEIGHT-1:0]  vert_q;
    logic               center_vld;
    logic [DIFF_W-1:0]  center;

    always_comb begin
        scanning   = (state_q == S_SCAN_H) || (state_q == S_SCAN_V);
        vert_pass  = (state_q == S_SCAN_V);
        inner      = vert_pass ? y_q : x_q;
        outer      = vert_pass ? x_q : y_q;
        inner_last = (inner == (vert_pass ? H_LAST : W_LAST));
        scan_last  = inner_last && (outer == (vert_pass ? W_LAST : H_LAST));
        drain_last = (drain_q == 2'(DRAIN_CYCLES - 1));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (bus.start_scan) state_d = S_CLEAR;
            S_CLEAR:   state_d = S_SCAN_H;
            S_SCAN_H:  if (scan_last) state_d = S_DRAIN_H;
            S_DRAIN_H: if (drain_last) state_d = S_SCAN_V;
            S_SCAN_V:  if (scan_last) state_d = S_DRAIN_V;
            S_DRAIN_V: if (drain_last) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= S_IDLE;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_DRAIN_H) || (state_q == S_DRAIN_V)) begin
                drain_q <= drain_q + 2'd1;
            end else begin
                drain_q <= '0;
            end
        end
    end

    // Address generation: x inner in the row pass, y inner in the column pass.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            x_q       <= '0;
            y_q       <= '0;
            address_q <= '0;
        end else if (scanning) begin
            address_q <= ADDR_W'(y_q) * ADDR_W'(WIDTH) + ADDR_W'(x_q);
            if (inner_last) begin
                if (vert_pass) begin
                    y_q <= '0;
                    x_q <= scan_last ? '0 : x_q + COORD_W'(1);
                end else begin
                    x_q <= '0;
                    y_q <= scan_last ? '0 : y_q + COORD_W'(1);
                end
            end else if (vert_pass) begin
                y_q <= y_q + COORD_W'(1);
            end else begin
                x_q <= x_q + COORD_W'(1);
            end
        end else begin
            x_q <= '0;
            y_q <= '0;
        end
    end

    // Stage p0: issued address; p1/p2 follow the frame-buffer read latency.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            vld_p0   <= 1'b0;
            pass_p0  <= 1'b0;
            coord_p0 <= '0;
            first_p0 <= 1'b0;
            last_p0  <= 1'b0;
            vld_p1   <= 1'b0;
            pass_p1  <= 1'b0;
            coord_p1 <= '0;
            first_p1 <= 1'b0;
            last_p1  <= 1'b0;
            vld_p2   <= 1'b0;
            pass_p2  <= 1'b0;
            coord_p2 <= '0;
            first_p2 <= 1'b0;
            last_p2  <= 1'b0;
        end else begin
            vld_p0   <= scanning;
            pass_p0  <= vert_pass;
            coord_p0 <= inner;
            first_p0 <= (inner == '0);
            last_p0  <= inner_last;
            vld_p1   <= vld_p0;
            pass_p1  <= pass_p0;
            coord_p1 <= coord_p0;
            first_p1 <= first_p0;
            last_p1  <= last_p0;
            vld_p2   <= vld_p1;
            pass_p2  <= pass_p1;
            coord_p2 <= coord_p1;
            first_p2 <= first_p1;
            last_p2  <= last_p1;
        end
    end

    // Stage p2: returned pixel meets its coordinate in the run tracker.
    finder_run_tracker #(
        .MIN_UNIT (MIN_UNIT)
    ) u_tracker (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .vld        (vld_p2),
        .line_start (first_p2),
        .line_end   (last_p2),
        .pixel      (bus.pixel_reading),
        .coord      (coord_p2),
        .center_vld (center_vld),
        .center     (center)
    );

    // Out-of-range centres shift the single set bit off the vector and are dropped.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            horz_q <= '0;
            vert_q <= '0;
        end else if (state_q == S_CLEAR) begin
            horz_q <= '0;
            vert_q <= '0;
        end else if (center_vld) begin
            if (pass_p2) begin
                vert_q <= vert_q | (V_ONE << center);
            end else begin
                horz_q <= horz_q | (H_ONE << center);
            end
        end
    end

    assign bus.address_reading = address_q;
    assign bus.horz_patterns   = horz_q;
    assign bus.vert_patterns   = vert_q;
    assign bus.busy            = (state_q != S_IDLE);
    assign bus.patterns_valid  = (state_q == S_DONE);

endmodule

// File: tb/tb_finder_pattern_scanner.sv
// Table-driven bench for finder_pattern_scanner on a reduced 64x32 frame.
// Expected vectors are queued when a scan starts and compared at patterns_valid.
module tb_finder_pattern_scanner;

    localparam int W   = 64;
    localparam int H   = 32;
    localparam int LAT = 7 + 2 * W * H;

    typedef struct {
        string name;
        int    kind;
        int    row;
        int    col;
        int    r0, r1, r2, r3, r4;
        int    exp_h;
        int    exp_v;
    } vec_t;

    typedef struct {
        string        name;
        logic [W-1:0] h;
        logic [H-1:0] v;
    } exp_t;

    logic clk;
    logic rst_n;
    logic img [W*H];
    logic rd1, rd2;
    exp_t sb [$];
    vec_t tbl [9];
    int   errors;
    int   checks;

    finder_pattern_scanner_if #(.WIDTH(W), .HEIGHT(H)) bus ();

    finder_pattern_scanner #(
        .WIDTH    (W),
        .HEIGHT   (H),
        .MIN_UNIT (4)
    ) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd1 <= img[bus.address_reading];
        rd2 <= rd1;
    end
    assign bus.pixel_reading = rd2;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic put_runs(input int row, input int x0, input int a, input int b,
                            input int c, input int d, input int e);
        int x;
        int r [5];
        r = '{a, b, c, d, e};
        x = x0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < r[i]; j++) begin
                img[row*W + x] = (i % 2 == 0) ? 1'b0 : 1'b1;
                x++;
            end
        end
    endtask

    task automatic build(input vec_t v);
        for (int i = 0; i < W*H; i++) img[i] = 1'b1;
        case (v.kind)
            0: put_runs(v.row, v.col, v.r0, v.r1, v.r2, v.r3, v.r4);
            1: begin
                for (int dy = 0; dy < 28; dy++) begin
                    for (int dx = 0; dx < 28; dx++) begin
                        if (dx < 4 || dx >= 24 || dy < 4 || dy >= 24 ||
                            (dx >= 8 && dx < 20 && dy >= 8 && dy < 20))
                            img[(v.row+dy)*W + v.col + dx] = 1'b0;
                    end
                end
            end
            default: begin
                put_runs(v.row, v.col, 4, 4, 12, 0, 0);
                put_runs(v.row + 1, 4, 4, 0, 0, 0, 0);
            end
        endcase
    endtask

    task automatic run_scan(input string name, input int exp_h, input int exp_v,
                            input int pulse_at, input bit pulse_done);
        exp_t e;
        exp_t got_e;
        int   k;
        bit   found;
        e.name = name;
        e.h    = '0;
        e.v    = '0;
        if (exp_h >= 0) e.h[exp_h] = 1'b1;
        if (exp_v >= 0) e.v[exp_v] = 1'b1;
        @(negedge clk);
        bus.start_scan = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus.start_scan = 1'b0;
        chk({name, "_busy_rise"}, 64'(bus.busy), 64'd1);
        k = 0;
        found = 1'b0;
        while (!found && k < LAT + 50) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            bus.start_scan = (k == pulse_at);
            if (bus.patterns_valid) begin
                found = 1'b1;
                chk({name, "_latency"}, 64'(k), 64'(LAT));
                if (sb.size() > 0) begin
                    got_e = sb.pop_front();
                    chk({got_e.name, "_horz"}, 64'(bus.horz_patterns), 64'(got_e.h));
                    chk({got_e.name, "_vert"}, 64'(bus.vert_patterns), 64'(got_e.v));
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL %s_scoreboard: got patterns_valid expected queued entry", name);
                end
                if (pulse_done) bus.start_scan = 1'b1;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no patterns_valid in %0d cycles expected one", name, k);
            if (sb.size() > 0) void'(sb.pop_front());
        end
        @(posedge clk);
        @(negedge clk);
        bus.start_scan = 1'b0;
        chk({name, "_valid_fall"}, 64'(bus.patterns_valid), 64'd0);
        chk({name, "_busy_fall"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int extra_pv;
        int busy_seen;
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        bus.start_scan = 1'b0;
        for (int i = 0; i < W*H; i++) img[i] = 1'b1;

        tbl[0] = '{"single_row",   0,  5, 10, 4, 4, 12, 4, 4, 23, -1};
        tbl[1] = '{"finder",       1,  2, 20, 0, 0,  0, 0, 0, 33, 15};
        tbl[2] = '{"reject_equal", 0,  7,  5, 4, 4,  4, 4, 4, -1, -1};
        tbl[3] = '{"reject_ones",  0,  9,  3, 1, 1,  1, 1, 1, -1, -1};
        tbl[4] = '{"min_unit",     0, 11, 30, 1, 1,  3, 1, 1, 33, -1};
        tbl[5] = '{"tol_edge_ok",  0, 15, 10, 4, 4, 12, 4, 7, 23, -1};
        tbl[6] = '{"tol_over",     0, 17, 10, 4, 4, 12, 4, 8, -1, -1};
        tbl[7] = '{"line_edge",    0, 20, 36, 4, 4, 12, 4, 4, 49, -1};
        tbl[8] = '{"split_rows",   2, 12, 44, 0, 0,  0, 0, 0, -1, -1};

        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_valid", 64'(bus.patterns_valid), 64'd0);
        chk("rst_addr", 64'(bus.address_reading), 64'd0);
        chk("rst_horz", 64'(bus.horz_patterns), 64'd0);
        chk("rst_vert", 64'(bus.vert_patterns), 64'd0);
        rst_n = 1'b1;

        // Reset asserted part-way through the row pass.
        build(tbl[0]);
        @(negedge clk);
        bus.start_scan = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start_scan = 1'b0;
        repeat (450) @(negedge clk);
        chk("midscan_horz", 64'(bus.horz_patterns), 64'd1 << 23);
        chk("midscan_busy", 64'(bus.busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", 64'(bus.busy), 64'd0);
        chk("async_addr", 64'(bus.address_reading), 64'd0);
        chk("async_horz", 64'(bus.horz_patterns), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_scan("after_reset", 23, -1, -1, 1'b0);

        for (int t = 0; t < 9; t++) begin
            build(tbl[t]);
            run_scan(tbl[t].name, tbl[t].exp_h, tbl[t].exp_v, -1, 1'b0);
        end

        // Extra start while busy and in the DONE cycle.
        build(tbl[1]);
        run_scan("handshake", 33, 15, 100, 1'b1);
        extra_pv = 0;
        busy_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.patterns_valid) extra_pv++;
            if (bus.busy) busy_seen++;
        end
        chk("hs_extra_valid", 64'(extra_pv), 64'd0);
        chk("hs_busy_after", 64'(busy_seen), 64'd0);
        chk("hs_horz_hold", 64'(bus.horz_patterns), 64'd1 << 33);
        chk("hs_vert_hold", 64'(bus.vert_patterns), 64'd1 << 15);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
